bram_stream_reader: RTL and testbench

//  Read-side master for the simple dual-port BRAM: drives its read port (enB/addrB, 1-cycle latency)
//  and streams a burst of words out on a valid/ready interface. A burst is set by a start address
//  and a length. The block sits between a BRAM filled via port A and a downstream stream consumer.

---
 rtl/bram_stream_reader_pkg.sv | 19 +
 rtl/bram_stream_reader_if.sv | 35 +++
 rtl/bram_stream_reader_fifo.sv | 55 +++++
 rtl/bram_stream_reader.sv | 125 ++++++++++++
 tb/tb_bram_stream_reader.sv | 265 ++++++++++++++++++++++++++
 5 files changed

// File: rtl/bram_stream_reader_pkg.sv
// Shared types and helpers for the BRAM read-side streamer: FSM encoding and
// a ceiling-log2 used to size FIFO pointers and occupancy counters.
package bram_stream_pkg;

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_RUN   = 2'd1,
        ST_DRAIN = 2'd2,
        ST_DONE  = 2'd3
    } state_e;

    function automatic int clog2(input int value);
        int r;
        r = 0;
        while ((1 << r) < value) r++;
        return r;
    endfunction

endpackage

// File: rtl/bram_stream_reader_if.sv
// Bundle of control, BRAM read-port and stream signals for bram_stream_reader.
// master = the reader block, slave = the environment (BRAM, controller, consumer).
interface bram_stream_reader_if
    import bram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1
) ();
    logic                  i_start;
    logic [ADDR_WIDTH-1:0] i_base_addr;
    logic [LEN_WIDTH-1:0]  i_len;
    logic                  o_busy;
    logic                  o_done;
    logic                  o_enB;
    logic [ADDR_WIDTH-1:0] o_addrB;
    logic [DATA_WIDTH-1:0] i_doutB;
    // Stream: a beat transfers on a cycle with o_tvalid & i_tready; once o_tvalid
    // is raised, o_tvalid/o_tdata/o_tlast hold unchanged until that transfer.
    logic                  o_tvalid;
    logic                  i_tready;
    logic [DATA_WIDTH-1:0] o_tdata;
    logic                  o_tlast;
    state_e                o_state;

    modport master (
        input  i_start, i_base_addr, i_len, i_doutB, i_tready,
        output o_busy, o_done, o_enB, o_addrB, o_tvalid, o_tdata, o_tlast, o_state
    );

    modport slave (
        output i_start, i_base_addr, i_len, i_doutB, i_tready,
        input  o_busy, o_done, o_enB, o_addrB, o_tvalid, o_tdata, o_tlast, o_state
    );
endinterface

// File: rtl/bram_stream_reader_fifo.sv
// Synchronous first-word-fall-through FIFO; DEPTH must be a power of two.
// Pushing into a full FIFO is prevented upstream by the reader's credit logic.
module stream_fifo
    import bram_stream_pkg::*;
#(
    parameter int WIDTH = 33,
    parameter int DEPTH = 4
) (
    input  logic                   i_clk,
    input  logic                   i_reset,
    input  logic                   push_i,
    input  logic [WIDTH-1:0]       data_i,
    input  logic                   pop_i,
    output logic                   valid_o,
    output logic [WIDTH-1:0]       data_o,
    output logic [clog2(DEPTH):0]  count_o
);
    localparam int PTR_W = clog2(DEPTH);
    localparam int CNT_W = PTR_W + 1;

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [PTR_W-1:0] wr_ptr_q, wr_ptr_d;
    logic [PTR_W-1:0] rd_ptr_q, rd_ptr_d;
    logic [CNT_W-1:0] count_q, count_d;
    logic             pop_ok;

    assign valid_o = (count_q != '0);
    assign pop_ok  = pop_i && valid_o;

    always_comb begin
        wr_ptr_d = wr_ptr_q + (push_i ? PTR_W'(1) : PTR_W'(0));
        rd_ptr_d = rd_ptr_q + (pop_ok ? PTR_W'(1) : PTR_W'(0));
        count_d  = count_q + CNT_W'(push_i) - CNT_W'(pop_ok);
    end

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            wr_ptr_q <= '0;
            rd_ptr_q <= '0;
            count_q  <= '0;
        end else begin
            wr_ptr_q <= wr_ptr_d;
            rd_ptr_q <= rd_ptr_d;
            count_q  <= count_d;
        end
    end

    always_ff @(posedge i_clk) begin
        if (push_i) mem_q[wr_ptr_q] <= data_i;
    end

    // Storage is not reset, so the head is masked to keep outputs at 0 when empty.
    assign data_o  = valid_o ? mem_q[rd_ptr_q] : '0;
    assign count_o = count_q;
endmodule

// File: rtl/bram_stream_reader.sv
// Read-side BRAM master: issues a burst of reads on port B under FIFO credit
// and streams the returned words out with tlast on the final beat.
module bram_stream_reader
    import bram_stream_pkg::*;
#(
    parameter int DATA_WIDTH = 32,
    parameter int ADDR_WIDTH = 10,
    parameter int LEN_WIDTH  = ADDR_WIDTH + 1,
    parameter int FIFO_DEPTH = 4
) (
    input  logic                 i_clk,
    input  logic                 i_reset,
    bram_stream_reader_if.master bus
);
    localparam int CNT_W = clog2(FIFO_DEPTH) + 1;
    localparam int OCC_W = CNT_W + 1;

    state_e                state_q, state_d;
    logic [ADDR_WIDTH-1:0] addr_q, addr_d;
    logic                  enb_q, enb_d;
    logic                  enb_last_q, enb_last_d;
    logic                  cap_q, cap_last_q;
    logic [LEN_WIDTH-1:0]  issued_q, issued_d;
    logic [LEN_WIDTH-1:0]  len_q, len_d;

    logic                  fifo_valid;
    logic [DATA_WIDTH:0]   fifo_rdata;
    logic [CNT_W-1:0]      fifo_count;
    logic [OCC_W-1:0]      occ;
    logic                  can_issue, pop, beat_last;
    logic                  busy, done;

    // Occupancy counts words already buffered plus reads whose data is still on its way.
    assign occ       = OCC_W'(fifo_count) + OCC_W'(enb_q) + OCC_W'(cap_q);
    assign can_issue = (issued_q != len_q) && (occ < OCC_W'(FIFO_DEPTH));
    assign pop       = fifo_valid && bus.i_tready;
    assign beat_last = pop && fifo_rdata[DATA_WIDTH];

    always_ff @(posedge i_clk) begin
        if (i_reset) begin
            state_q    <= ST_IDLE;
            addr_q     <= '0;
            enb_q      <= 1'b0;
            enb_last_q <= 1'b0;
            cap_q      <= 1'b0;
            cap_last_q <= 1'b0;
            issued_q   <= '0;
            len_q      <= '0;
        end else begin
            state_q    <= state_d;
            addr_q     <= addr_d;
            enb_q      <= enb_d;
            enb_last_q <= enb_last_d;
            cap_q      <= enb_q;
            cap_last_q <= enb_last_q;
            issued_q   <= issued_d;
            len_q      <= len_d;
        end
    end

    always_comb begin
        state_d = state_q;
        unique case (state_q)
            ST_IDLE:  if (bus.i_start) state_d = (bus.i_len == '0) ? ST_DONE : ST_RUN;
            ST_RUN:   if (issued_q == len_q) state_d = ST_DRAIN;
            ST_DRAIN: if (beat_last) state_d = ST_DONE;
            ST_DONE:  state_d = ST_IDLE;
            default:  state_d = ST_IDLE;
        endcase
    end

    // The first read is issued straight from IDLE; the FIFO is always empty there.
    always_comb begin
        addr_d     = addr_q;
        enb_d      = 1'b0;
        enb_last_d = 1'b0;
        issued_d   = issued_q;
        len_d      = len_q;
        if (state_q == ST_IDLE && bus.i_start) begin
            len_d      = bus.i_len;
            addr_d     = bus.i_base_addr;
            enb_d      = (bus.i_len != '0);
            enb_last_d = (bus.i_len == LEN_WIDTH'(1));
            issued_d   = (bus.i_len != '0) ? LEN_WIDTH'(1) : '0;
        end else if (state_q == ST_RUN && can_issue) begin
            addr_d     = addr_q + ADDR_WIDTH'(1);
            enb_d      = 1'b1;
            enb_last_d = ((issued_q + LEN_WIDTH'(1)) == len_q);
            issued_d   = issued_q + LEN_WIDTH'(1);
        end
    end

    always_comb begin
        busy = 1'b0;
        done = 1'b0;
        unique case (state_q)
            ST_RUN, ST_DRAIN: busy = 1'b1;
            ST_DONE:          done = 1'b1;
            default:          ;
        endcase
    end

    stream_fifo #(
        .WIDTH (DATA_WIDTH + 1),
        .DEPTH (FIFO_DEPTH)
    ) u_fifo (
        .i_clk   (i_clk),
        .i_reset (i_reset),
        .push_i  (cap_q),
        .data_i  ({cap_last_q, bus.i_doutB}),
        .pop_i   (pop),
        .valid_o (fifo_valid),
        .data_o  (fifo_rdata),
        .count_o (fifo_count)
    );

    assign bus.o_busy   = busy;
    assign bus.o_done   = done;
    assign bus.o_enB    = enb_q;
    assign bus.o_addrB  = addr_q;
    assign bus.o_tvalid = fifo_valid;
    assign bus.o_tdata  = fifo_rdata[DATA_WIDTH-1:0];
    assign bus.o_tlast  = fifo_rdata[DATA_WIDTH];
    assign bus.o_state  = state_q;
endmodule

// File: tb/tb_bram_stream_reader.sv
// Directed bench for bram_stream_reader against a 1-cycle BRAM model holding ram[a]=3*a.
module tb_bram_stream_reader;

    localparam int DW = 32;
    localparam int AW = 10;
    localparam int LW = 11;
    localparam int FD = 4;

    logic clk;
    logic rst;

    bram_stream_reader_if #(.DATA_WIDTH(DW), .ADDR_WIDTH(AW), .LEN_WIDTH(LW)) bus ();

    bram_stream_reader #(
        .DATA_WIDTH (DW),
        .ADDR_WIDTH (AW),
        .LEN_WIDTH  (LW),
        .FIFO_DEPTH (FD)
    ) dut (
        .i_clk   (clk),
        .i_reset (rst),
        .bus     (bus)
    );

    // ---------------- clock / reset ----------------
    initial begin
        clk = 1'b0;
        forever #5 clk = ~clk;
    end

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    initial begin
        #100000;
        $display("FAIL watchdog: simulation exceeded its time limit");
        $fatal(1, "watchdog");
    end

    // BRAM model; output is scrambled when not enabled so stray captures show up.
    always @(posedge clk) begin
        if (bus.o_enB) bus.i_doutB <= 32'(3 * int'(bus.o_addrB));
        else           bus.i_doutB <= $urandom;
    end

    // ---------------- scoreboard ----------------
    logic [DW:0]   exp_q[$];
    logic [AW-1:0] addr_exp_q[$];

    int vectors     = 0;
    int miscompares = 0;

    int out_cnt        = 0;
    int beats_seen     = 0;
    int first_beat_cyc = -1;
    int last_beat_cyc  = -1;
    int first_valid_cyc = -1;
    int done_cnt       = 0;
    int done_cyc       = -1;
    int done_mark      = 0;
    int enb_seen       = 0;
    int tvalid_seen    = 0;
    int tready_mode    = 0;
    logic        prev_stall = 1'b0;
    logic [DW:0] prev_beat  = '0;

    task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vectors++;
        assert (obs === exp)
        else begin
            miscompares++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            logic ok;
            logic [DW:0] e;
            if (prev_stall) begin
                check("hold_valid", 64'(bus.o_tvalid), 64'(1));
                check("hold_beat", 64'({bus.o_tlast, bus.o_tdata}), 64'(prev_beat));
            end
            if (bus.o_tvalid) begin
                tvalid_seen++;
                if (first_valid_cyc < 0) first_valid_cyc = cyc;
            end
            if (bus.o_enB) begin
                enb_seen++;
                out_cnt++;
                ok = (addr_exp_q.size() != 0);
                check("read_expected", 64'(ok), 64'(1));
                if (ok) check("addrB", 64'(bus.o_addrB), 64'(addr_exp_q.pop_front()));
            end
            if (bus.o_tvalid && bus.i_tready) begin
                out_cnt--;
                beats_seen++;
                if (beats_seen == 1) first_beat_cyc = cyc;
                last_beat_cyc = cyc;
                ok = (exp_q.size() != 0);
                check("beat_expected", 64'(ok), 64'(1));
                if (ok) begin
                    e = exp_q.pop_front();
                    check("tdata", 64'(bus.o_tdata), 64'(e[DW-1:0]));
                    check("tlast", 64'(bus.o_tlast), 64'(e[DW]));
                end
            end
            if (bus.o_enB) check("credit", 64'(out_cnt <= FD), 64'(1));
            if (bus.o_done) begin
                done_cnt++;
                done_cyc = cyc;
                check("busy_at_done", 64'(bus.o_busy), 64'(0));
            end
            prev_stall = bus.o_tvalid && !bus.i_tready;
            prev_beat  = {bus.o_tlast, bus.o_tdata};
        end
    end

    // ---------------- driver tasks ----------------
    initial begin
        bus.i_tready = 1'b1;
        forever begin
            @(posedge clk);
            #1;
            if (tready_mode == 1) bus.i_tready = ~bus.i_tready;
            else                  bus.i_tready = 1'b1;
        end
    end

    task automatic tick(input int n);
        repeat (n) begin
            @(posedge clk);
            #1;
        end
    endtask

    task automatic start_burst(input logic [AW-1:0] base, input logic [LW-1:0] len, output int n);
        logic [AW-1:0] a;
        for (int i = 0; i < int'(len); i++) begin
            a = base + AW'(i);
            addr_exp_q.push_back(a);
            exp_q.push_back({(i == int'(len) - 1), 32'(3 * int'(a))});
        end
        beats_seen      = 0;
        first_valid_cyc = -1;
        done_mark       = done_cnt;
        bus.i_base_addr = base;
        bus.i_len       = len;
        bus.i_start     = 1'b1;
        n = cyc;
        tick(1);
        bus.i_start = 1'b0;
    endtask

    task automatic wait_done(input string tag, input int budget);
        for (int i = 0; i < budget; i++) begin
            if (done_cnt != done_mark) break;
            tick(1);
        end
        check(tag, 64'(done_cnt != done_mark), 64'(1));
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"},   64'(bus.o_busy),   64'(0));
        check({tag, "_done"},   64'(bus.o_done),   64'(0));
        check({tag, "_enB"},    64'(bus.o_enB),    64'(0));
        check({tag, "_addrB"},  64'(bus.o_addrB),  64'(0));
        check({tag, "_tvalid"}, 64'(bus.o_tvalid), 64'(0));
        check({tag, "_tdata"},  64'(bus.o_tdata),  64'(0));
        check({tag, "_tlast"},  64'(bus.o_tlast),  64'(0));
    endtask

    // ---------------- directed sequence ----------------
    initial begin
        int n;
        int d0;
        int e0;
        int v0;
        rst             = 1'b1;
        bus.i_start     = 1'b0;
        bus.i_base_addr = '0;
        bus.i_len       = '0;
        tick(3);
        rst = 1'b0;
        check_idle_outputs("reset");

        // 1: basic burst, latency and done timing
        start_burst(10'h010, 11'd4, n);
        check("t1_busy", 64'(bus.o_busy), 64'(1));
        wait_done("t1_done", 40);
        check("t1_first_valid", 64'(first_valid_cyc), 64'(n + 3));
        check("t1_done_after_last", 64'(done_cyc), 64'(last_beat_cyc + 1));
        check("t1_beats", 64'(beats_seen), 64'(4));
        check("t1_busy_after", 64'(bus.o_busy), 64'(0));
        tick(2);

        // 2: address wrap at top of memory
        start_burst(10'h3FE, 11'd4, n);
        wait_done("t2_done", 40);
        check("t2_beats", 64'(beats_seen), 64'(4));
        tick(2);

        // 3: alternating backpressure
        tready_mode = 1;
        start_burst(10'h040, 11'd8, n);
        wait_done("t3_done", 80);
        check("t3_beats", 64'(beats_seen), 64'(8));
        tready_mode = 0;
        tick(3);

        // 4: zero length
        e0 = enb_seen;
        v0 = tvalid_seen;
        start_burst(10'h055, 11'd0, n);
        wait_done("t4_done", 10);
        check("t4_done_cyc", 64'(done_cyc), 64'(n + 1));
        tick(4);
        check("t4_no_read", 64'(enb_seen), 64'(e0));
        check("t4_no_valid", 64'(tvalid_seen), 64'(v0));

        // 5: reset mid-burst after beat 3
        start_burst(10'h000, 11'd8, n);
        d0 = done_cnt;
        for (int i = 0; i < 40; i++) begin
            if (beats_seen >= 3) break;
            tick(1);
        end
        check("t5_reached_beat3", 64'(beats_seen >= 3), 64'(1));
        rst = 1'b1;
        tick(1);
        rst = 1'b0;
        exp_q.delete();
        addr_exp_q.delete();
        out_cnt = 0;
        check_idle_outputs("t5_abort");
        tick(12);
        check("t5_no_done", 64'(done_cnt), 64'(d0));
        start_burst(10'h020, 11'd2, n);
        wait_done("t5_restart_done", 40);
        check("t5_restart_beats", 64'(beats_seen), 64'(2));
        tick(2);

        // 6: sustained throughput; a start mid-burst is ignored
        start_burst(10'h080, 11'd16, n);
        d0 = done_cnt;
        tick(5);
        bus.i_base_addr = 10'h200;
        bus.i_len       = 11'd3;
        bus.i_start     = 1'b1;
        tick(1);
        bus.i_start = 1'b0;
        wait_done("t6_done", 80);
        check("t6_beats", 64'(beats_seen), 64'(16));
        check("t6_span", 64'(last_beat_cyc - first_beat_cyc), 64'(15));
        tick(6);
        check("t6_single_done", 64'(done_cnt), 64'(d0 + 1));

        check("sb_beats_empty", 64'(exp_q.size()), 64'(0));
        check("sb_reads_empty", 64'(addr_exp_q.size()), 64'(0));

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
